aes_inv_keyexpand: RTL and testbench

- Sequential inverse AES-128 key schedule for the decryption path.
- Takes the final (round-10) round key, normally captured from the forward key expansion, and regenerates round keys 10, 9, …, 0 one per cycle.
- Streams the keys to the inverse-round datapath over a valid/ready handshake, so the decrypt side never stores all 11 round keys.

---
 rtl/aes_inv_keyexpand.sv | 146 ++++++++++++++
 tb/tb_aes_inv_keyexpand.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_keyexpand.sv
// Inverse AES-128 key schedule: starts from the round-10 key and streams
// round keys 10 down to 0 over a valid/ready handshake, one per transfer.
module aes_inv_keyexpand (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Forward AES S-box, one row of 16 bytes per high nibble.
  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX_ROWS[b[7:4]];
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic         rk_valid_q, rk_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_word, sub_word;
  logic [127:0] prev_key;

  // Undo one forward expansion step; p3 must be recovered before p0 can use it.
  always_comb begin
    w0 = rk_out_q[127:96];
    w1 = rk_out_q[95:64];
    w2 = rk_out_q[63:32];
    w3 = rk_out_q[31:0];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    rot_word = {p3[23:0], p3[31:24]};
    sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
    p0 = w0 ^ sub_word ^ {rcon(rk_round_q), 24'h0};
    prev_key = {p0, p1, p2, p3};
  end

  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = EMIT;
          rk_out_d   = key_in;
          rk_round_d = 4'd10;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (rk_round_q != 4'd0) begin
            rk_out_d   = prev_key;
            rk_round_d = rk_round_q - 4'd1;
          end else begin
            state_d    = IDLE;
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_out_q   <= rk_out_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;
  assign rk_round = rk_round_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_keyexpand.sv
// Directed and randomized bench for aes_inv_keyexpand; expected round keys
// come from a GF(2^8)-derived S-box and a word-level forward/inverse key schedule.
module tb_aes_inv_keyexpand;

  logic         clk = 1'b0;
  logic         reset, start, rk_ready;
  logic [127:0] key_in;
  logic         rk_valid, busy, done;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk [11];

  always #5 clk = ~clk;

  aes_inv_keyexpand dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_round(rk_round), .busy(busy), .done(done)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse (a^254) in GF(2^8).
  task automatic buildSbox();
    logic [7:0] b, inv;
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, b);
      if (i == 0) inv = 8'h00;
      sbox_ref[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rconRef(input int j);
    logic [7:0] rc;
    rc = 8'h01;
    for (int k = 1; k < j; k++) rc = xtime(rc);
    return rc;
  endfunction

  function automatic logic [31:0] subRotWord(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_ref[r[31:24]], sbox_ref[r[23:16]], sbox_ref[r[15:8]], sbox_ref[r[7:0]]};
  endfunction

  task automatic expandKey(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subRotWord(t) ^ {rconRef(i / 4), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic invModel(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[40+i] = k10[127 - 32*i -: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i+3];
      if (i % 4 == 0) t = subRotWord(t) ^ {rconRef(i / 4 + 1), 24'h0};
      w[i] = w[i+4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [127:0] k, input logic rdy);
    start = s;
    key_in = k;
    rk_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] randKey();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int idx;
    logic rdy;
    logic finished;
    logic [127:0] k;

    buildSbox();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    step(); step();
    checkOutput("reset_valid", rk_valid, 0);
    checkOutput("reset_out", rk_out, 0);
    checkOutput("reset_round", rk_round, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    reset = 1'b0;
    step();
    checkOutput("idle_valid", rk_valid, 0);

    // FIPS-197 example with rk_ready held high
    expandKey(128'h2b7e151628aed2a6abf7158809cf4f3c);
    applyStimulus(1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
    step();
    applyStimulus(1'b0, randKey(), 1'b1);
    for (int r = 10; r >= 0; r--) begin
      checkOutput("fips_valid", rk_valid, 1);
      checkOutput("fips_round", rk_round, r);
      checkOutput("fips_key", rk_out, exp_rk[r]);
      checkOutput("fips_busy", busy, 1);
      checkOutput("fips_done_low", done, 0);
      if (r == 10) checkOutput("fips_const_r10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      if (r == 9)  checkOutput("fips_const_r9", rk_out, 128'hac7766f319fadc2128d12941575c006e);
      if (r == 1)  checkOutput("fips_const_r1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
      if (r == 0)  checkOutput("fips_const_r0", rk_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      step();
    end
    checkOutput("fips_done", done, 1);
    checkOutput("fips_end_valid", rk_valid, 0);
    checkOutput("fips_end_busy", busy, 0);
    step();
    checkOutput("fips_done_single", done, 0);

    // Random key with random backpressure
    expandKey(randKey());
    applyStimulus(1'b1, exp_rk[10], 1'b0);
    step();
    applyStimulus(1'b0, randKey(), 1'b0);
    idx = 10;
    finished = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      checkOutput("bp_valid", rk_valid, 1);
      checkOutput("bp_round", rk_round, idx);
      checkOutput("bp_key", rk_out, exp_rk[idx]);
      checkOutput("bp_done_low", done, 0);
      rdy = 1'($urandom_range(0, 1));
      rk_ready = rdy;
      step();
      if (rdy) begin
        if (idx == 0) finished = 1'b1;
        else idx--;
      end
    end
    checkOutput("bp_completed", finished, 1);
    checkOutput("bp_done", done, 1);
    rk_ready = 1'b0;
    step();

    // Start pulse in mid-run with a different key is ignored
    k = randKey();
    expandKey(k);
    applyStimulus(1'b1, exp_rk[10], 1'b1);
    step();
    for (int r = 10; r >= 0; r--) begin
      checkOutput("ign_round", rk_round, r);
      checkOutput("ign_key", rk_out, exp_rk[r]);
      checkOutput("ign_busy", busy, 1);
      applyStimulus(r == 6, (r == 6) ? ~k : exp_rk[10], 1'b1);
      step();
    end
    checkOutput("ign_done", done, 1);
    step();

    // Reset in mid-run at round 5 with the consumer stalled
    expandKey(randKey());
    applyStimulus(1'b1, exp_rk[10], 1'b1);
    step();
    for (int r = 10; r >= 6; r--) begin
      applyStimulus(1'b0, exp_rk[10], 1'b1);
      step();
    end
    checkOutput("rst_pre_round", rk_round, 5);
    reset = 1'b1;
    applyStimulus(1'b0, exp_rk[10], 1'b0);
    step();
    reset = 1'b0;
    checkOutput("rst_valid", rk_valid, 0);
    checkOutput("rst_out", rk_out, 0);
    checkOutput("rst_round", rk_round, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    step();
    checkOutput("rst_no_done", done, 0);
    checkOutput("rst_idle_valid", rk_valid, 0);

    expandKey(randKey());
    applyStimulus(1'b1, exp_rk[10], 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("restart_round", rk_round, 10);
    checkOutput("restart_key", rk_out, exp_rk[10]);
    step();
    checkOutput("stall_round", rk_round, 10);
    checkOutput("stall_key", rk_out, exp_rk[10]);
    rk_ready = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      checkOutput("restart_run_round", rk_round, r);
      checkOutput("restart_run_key", rk_out, exp_rk[r]);
      step();
    end
    checkOutput("restart_done", done, 1);

    // Back-to-back start in the done cycle, using the all-zero key
    applyStimulus(1'b1, '0, 1'b1);
    invModel('0);
    step();
    applyStimulus(1'b0, randKey(), 1'b1);
    checkOutput("b2b_valid", rk_valid, 1);
    checkOutput("b2b_busy", busy, 1);
    for (int r = 10; r >= 0; r--) begin
      checkOutput("zero_round", rk_round, r);
      checkOutput("zero_key", rk_out, exp_rk[r]);
      step();
    end
    checkOutput("zero_done", done, 1);
    step();
    checkOutput("zero_done_single", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
